// File: rtl/pif_led_breather.sv
// Multi-channel LED breather: step-tick divider, shared PWM counter,
// per-channel off/on/breathe/blink modes on active-low pins.
module pif_led_breather #(
  parameter int CHANNELS = 2,
  parameter int B        = 5,
  parameter int TICK_DIV = 177333
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [2*CHANNELS-1:0] Mode,
  output logic [CHANNELS-1:0]   LedN,
  output logic                  Tick,
  output logic                  Wrap
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);
  localparam logic [B-1:0]  LMAX   = '1;

  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_ON      = 2'd1;
  localparam logic [1:0] M_BREATHE = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  logic [CW-1:0]       tick_cnt;
  logic [B-1:0]        pwm;
  logic [B-1:0]        level  [CHANNELS];
  logic [B-1:0]        step   [CHANNELS];
  logic [1:0]          mode_q [CHANNELS];
  logic [CHANNELS-1:0] dir_dn;
  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] led_d;

  // Step divider and free-running PWM counter, both frozen when disabled
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick_cnt <= RELOAD;
      pwm      <= '0;
      Tick     <= 1'b0;
    end else if (Enable) begin
      pwm <= pwm + 1'b1;
      if (tick_cnt == '0) begin
        tick_cnt <= RELOAD;
        Tick     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
        Tick     <= 1'b0;
      end
    end else begin
      Tick <= 1'b0;
    end
  end

  // Next ramp value, end-of-ramp detect and mode-change detect per channel
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      step[n] = dir_dn[n] ? level[n] - 1'b1 : level[n] + 1'b1;
      flip[n] = dir_dn[n] ? (level[n] == B'(1))
                          : (level[n] == LMAX - 1'b1);
      chg[n]  = (mode_q[n] != Mode[2*n +: 2]);
    end
  end

  // Ramp state; a mode change restarts the ramp and beats a tick
  always_ff @(posedge Clk) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (Rst) begin
        level[n]  <= '0;
        dir_dn[n] <= 1'b0;
        mode_q[n] <= Mode[2*n +: 2];
      end else if (chg[n]) begin
        level[n]  <= '0;
        dir_dn[n] <= 1'b0;
        mode_q[n] <= Mode[2*n +: 2];
      end else if (Tick && mode_q[n][1]) begin
        level[n] <= step[n];
        if (flip[n]) dir_dn[n] <= ~dir_dn[n];
      end
    end
  end

  // Per-channel pin value from current PWM, level and direction
  always_comb begin
    led_d = '1;
    for (int n = 0; n < CHANNELS; n++) begin
      if (Enable) begin
        unique case (mode_q[n])
          M_OFF:     led_d[n] = 1'b1;
          M_ON:      led_d[n] = 1'b0;
          M_BREATHE: led_d[n] = !(pwm < level[n]);
          M_BLINK:   led_d[n] = dir_dn[n];
        endcase
      end
    end
  end

  // Registered pins and channel-0 direction-reversal pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      LedN <= '1;
      Wrap <= 1'b0;
    end else begin
      LedN <= led_d;
      Wrap <= Tick && mode_q[0][1] && !chg[0] && flip[0];
    end
  end

endmodule
